// File: rtl/pakin_io_mch_if.sv
// pakin_io_mch_if: packet-out and message-in handshake bundle for the
// multi-channel pakin link exerciser. The master side is the exerciser.
`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 8
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

interface pakin_io_mch_if #(
   parameter int NCH = 2,
   parameter int PSZ = `NS_PACKET_SIZE,
   parameter int MSZ = 2*`NS_ADDRESS_SIZE + `NS_DATA_SIZE + `NS_REDUN_SIZE
);
   logic [NCH*PSZ-1:0] o_pakio;
   logic [NCH-1:0]     o_req;
   logic [NCH-1:0]     o_ack;
   logic [NCH*MSZ-1:0] i_msg;
   logic [NCH-1:0]     i_req;
   logic [NCH-1:0]     i_ack;

   modport master (output o_pakio, o_req, i_ack, input o_ack, i_msg, i_req);
   modport slave  (input o_pakio, o_req, i_ack, output o_ack, i_msg, i_req);
endinterface

// File: rtl/pakin_io_mch.sv
// pakin_io_mch: NCH independent packet-out generators and message-in checkers.
// Each generator builds {src,dst,dat,red} messages into a small FIFO and sends
// them as TOT_PKS packets over a 4-phase req/ack link; each checker takes whole
// messages over a 4-phase link and keeps sticky src/red/sequence error flags.
// Optional build macro PAKIN_IO_ERR_CNT_EN adds a saturating per-channel
// count of errored messages (port err_cnt).
`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 8
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

// One channel: generator + FIFO + packet sender, and a message checker.
module pakin_io_ch #(
   parameter int MIN_ADDR = 1,
   parameter int MAX_ADDR = 1,
   parameter int SRC_ADDR = 3,
   parameter int FDEPTH   = 4,
   parameter int PSZ      = 8,
   parameter int ASZ      = 4,
   parameter int DSZ      = 8,
   parameter int RSZ      = 4,
   parameter bit DBG_EN   = 1'b0,
   localparam int MSZ     = 2*ASZ + DSZ + RSZ,
   localparam int TOT_PKS = (MSZ + PSZ - 1) / PSZ
) (
   input  logic           src_clk,
   input  logic           reset,
   output logic [PSZ-1:0] o_pakio,
   output logic           o_req,
   input  logic           o_ack,
   input  logic [MSZ-1:0] i_msg,
   input  logic           i_req,
   output logic           i_ack,
   output logic           err_src,
   output logic           err_red,
   output logic           err_seq,
   output logic [3:0]     dbg_dat
`ifdef PAKIN_IO_ERR_CNT_EN
   ,output logic [7:0]    err_cnt
`endif
);
   localparam int AW = $clog2(FDEPTH);
   localparam int TW = TOT_PKS * PSZ;
   localparam int IW = $clog2(TOT_PKS + 1);

   typedef struct packed {
      logic [ASZ-1:0] src;
      logic [ASZ-1:0] dst;
      logic [DSZ-1:0] dat;
      logic [RSZ-1:0] red;
   } msg_t;

   // Redundancy: XOR-fold of {src,dst,dat} into RSZ bits.
   function automatic logic [RSZ-1:0] calc_redun(input logic [2*ASZ+DSZ-1:0] v);
      logic [RSZ-1:0] r;
      r = '0;
      for (int i = 0; i < 2*ASZ+DSZ; i++) r[i % RSZ] = r[i % RSZ] ^ v[i];
      return r;
   endfunction

   // ---------------- synchronisers ----------------
   logic [1:0] ack_sync, req_sync;
   logic       ack_s, req_s;
   assign ack_s = ack_sync[1];
   assign req_s = req_sync[1];

   // two-flop synchronisers for the asynchronous handshake inputs
   always_ff @(posedge src_clk or negedge reset)
      if (!reset) begin
         ack_sync <= '0;
         req_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[0], o_ack};
         req_sync <= {req_sync[0], i_req};
      end

   // ---------------- generator ----------------
   typedef enum logic [1:0] {G_DST, G_DAT, G_RED, G_PUSH} g_st_t;
   g_st_t          g_st, g_nx;
   logic [ASZ-1:0] g_dst;
   logic [DSZ-1:0] g_dat, g_cnt;
   logic [RSZ-1:0] g_red;
   logic           push, pop, full, empty;

   // generator state register and message fields
   always_ff @(posedge src_clk or negedge reset)
      if (!reset) begin
         g_st  <= G_DST;
         g_dst <= ASZ'(MIN_ADDR - 1);
         g_dat <= '0;
         g_cnt <= DSZ'(5);
         g_red <= '0;
      end else begin
         g_st <= g_nx;
         case (g_st)
            G_DST:   g_dst <= (g_dst >= ASZ'(MAX_ADDR)) ? ASZ'(MIN_ADDR) : g_dst + 1'b1;
            G_DAT:   begin g_dat <= g_cnt; g_cnt <= g_cnt + 1'b1; end
            G_RED:   g_red <= calc_redun({ASZ'(SRC_ADDR), g_dst, g_dat});
            default: ;
         endcase
      end

   // generator next state: fixed walk, waits in G_PUSH for room
   always_comb begin
      g_nx = g_st;
      case (g_st)
         G_DST:  g_nx = G_DAT;
         G_DAT:  g_nx = G_RED;
         G_RED:  g_nx = G_PUSH;
         G_PUSH: if (push) g_nx = G_DST;
         default: g_nx = G_DST;
      endcase
   end

   // ---------------- FIFO ----------------
   msg_t          mem [FDEPTH];
   logic [AW:0]   wptr, rptr;
   msg_t          g_msg, f_rd;

   assign g_msg = '{src: ASZ'(SRC_ADDR), dst: g_dst, dat: g_dat, red: g_red};
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   // a pop in the same cycle frees the slot being written, so full+pop may push
   assign push  = (g_st == G_PUSH) && (!full || pop);
   assign f_rd  = mem[rptr[AW-1:0]];

   // FIFO storage, no reset needed
   always_ff @(posedge src_clk)
      if (push) mem[wptr[AW-1:0]] <= g_msg;

   // FIFO pointers
   always_ff @(posedge src_clk or negedge reset)
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end

   // ---------------- sender ----------------
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT} s_st_t;
   s_st_t         s_st, s_nx;
   logic [TW-1:0] shreg;
   logic [IW-1:0] idx;
   logic          last_pk;

   assign pop     = (s_st == S_LOAD);
   assign last_pk = (idx == IW'(TOT_PKS - 1));
   assign o_req   = (s_st == S_REQ);
   // current packet always sits in the top PSZ bits of the shift register
   assign o_pakio = o_req ? shreg[TW-1 -: PSZ] : '0;

   // sender state register, shift register and packet index
   always_ff @(posedge src_clk or negedge reset)
      if (!reset) begin
         s_st  <= S_IDLE;
         shreg <= '0;
         idx   <= '0;
      end else begin
         s_st <= s_nx;
         if (s_st == S_LOAD) begin
            shreg <= TW'(f_rd) << (TW - MSZ);   // MSB aligned, tail zero-padded
            idx   <= '0;
         end else if (s_st == S_WAIT && !ack_s && !last_pk) begin
            shreg <= shreg << PSZ;
            idx   <= idx + 1'b1;
         end
      end

   // sender next state: 4-phase handshake per packet
   always_comb begin
      s_nx = s_st;
      case (s_st)
         S_IDLE: if (!empty) s_nx = S_LOAD;
         S_LOAD: s_nx = S_REQ;
         S_REQ:  if (ack_s) s_nx = S_WAIT;
         S_WAIT: if (!ack_s) s_nx = last_pk ? S_IDLE : S_REQ;
         default: s_nx = S_IDLE;
      endcase
   end

   // ---------------- checker ----------------
   typedef enum logic [2:0] {C_IDLE, C_CAP, C_RED, C_CHK, C_ACK} c_st_t;
   c_st_t          c_st, c_nx;
   msg_t           c_msg;
   logic [RSZ-1:0] c_red;
   logic [DSZ-1:0] ref_dat;
   logic           ref_vld;
   logic           e_src, e_red, e_seq;

   assign e_src = (c_msg.src != ASZ'(SRC_ADDR));
   assign e_red = (c_msg.red != c_red);
   assign e_seq = ref_vld && (c_msg.dat != ref_dat + 1'b1);

   // checker state register, capture, sticky flags and sequence reference
   always_ff @(posedge src_clk or negedge reset)
      if (!reset) begin
         c_st    <= C_IDLE;
         c_msg   <= '0;
         c_red   <= '0;
         ref_dat <= '0;
         ref_vld <= 1'b0;
         i_ack   <= 1'b0;
         err_src <= 1'b0;
         err_red <= 1'b0;
         err_seq <= 1'b0;
`ifdef PAKIN_IO_ERR_CNT_EN
         err_cnt <= '0;
`endif
      end else begin
         c_st <= c_nx;
         case (c_st)
            C_CAP: c_msg <= msg_t'(i_msg);
            C_RED: c_red <= calc_redun({c_msg.src, c_msg.dst, c_msg.dat});
            C_CHK: begin
               if (e_src) err_src <= 1'b1;
               if (e_red) err_red <= 1'b1;
               if (e_seq) err_seq <= 1'b1;
`ifdef PAKIN_IO_ERR_CNT_EN
               if ((e_src || e_red || e_seq) && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
`endif
               ref_dat <= c_msg.dat;   // always resync, even after an error
               ref_vld <= 1'b1;
               i_ack   <= 1'b1;
            end
            C_ACK: if (!req_s) i_ack <= 1'b0;
            default: ;
         endcase
      end

   // checker next state
   always_comb begin
      c_nx = c_st;
      case (c_st)
         C_IDLE: if (req_s && !i_ack) c_nx = C_CAP;
         C_CAP:  c_nx = C_RED;
         C_RED:  c_nx = C_CHK;
         C_CHK:  c_nx = C_ACK;
         C_ACK:  if (!req_s) c_nx = C_IDLE;
         default: c_nx = C_IDLE;
      endcase
   end

   // debug tap of the last accepted dat nibble (DSZ >= 4 assumed)
   if (DBG_EN) begin : g_dbg
      logic [3:0] dbg_q;
      // latch low nibble when a message is accepted
      always_ff @(posedge src_clk or negedge reset)
         if (!reset)              dbg_q <= '0;
         else if (c_st == C_CHK)  dbg_q <= c_msg.dat[3:0];
      assign dbg_dat = dbg_q;
   end else begin : g_nodbg
      assign dbg_dat = '0;
   end
endmodule

module pakin_io_mch #(
   parameter int NCH      = 2,
   parameter int MIN_ADDR = 1,
   parameter int MAX_ADDR = 1,
   parameter int SRC_ADDR = 3,
   parameter int FDEPTH   = 4,
   parameter int PSZ      = `NS_PACKET_SIZE,
   parameter int ASZ      = `NS_ADDRESS_SIZE,
   parameter int DSZ      = `NS_DATA_SIZE,
   parameter int RSZ      = `NS_REDUN_SIZE,
   localparam int MSZ     = 2*ASZ + DSZ + RSZ
) (
   input  logic             src_clk,
   input  logic             reset,
   pakin_io_mch_if.master   bus,
   output logic [NCH-1:0]   err_src,
   output logic [NCH-1:0]   err_red,
   output logic [NCH-1:0]   err_seq,
   output logic [3:0]       dbg_dat
`ifdef PAKIN_IO_ERR_CNT_EN
   ,output logic [NCH*8-1:0] err_cnt
`endif
);
   logic [NCH-1:0][3:0] dbg_ch;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      pakin_io_ch #(
         .MIN_ADDR (MIN_ADDR), .MAX_ADDR (MAX_ADDR), .SRC_ADDR (SRC_ADDR),
         .FDEPTH   (FDEPTH),   .PSZ (PSZ), .ASZ (ASZ), .DSZ (DSZ), .RSZ (RSZ),
         .DBG_EN   (k == 0)
      ) u_ch (
         .src_clk (src_clk),
         .reset   (reset),
         .o_pakio (bus.o_pakio[k*PSZ +: PSZ]),
         .o_req   (bus.o_req[k]),
         .o_ack   (bus.o_ack[k]),
         .i_msg   (bus.i_msg[k*MSZ +: MSZ]),
         .i_req   (bus.i_req[k]),
         .i_ack   (bus.i_ack[k]),
         .err_src (err_src[k]),
         .err_red (err_red[k]),
         .err_seq (err_seq[k]),
         .dbg_dat (dbg_ch[k])
`ifdef PAKIN_IO_ERR_CNT_EN
         ,.err_cnt (err_cnt[k*8 +: 8])
`endif
      );
   end

   // only channel 0 drives a non-zero debug nibble; the rest tie off to 0
   always_comb begin
      dbg_dat = '0;
      for (int k = 0; k < NCH; k++) dbg_dat = dbg_dat | dbg_ch[k];
   end
endmodule

// File: tb/tb_pakin_io_mch.sv
// Directed bench for pakin_io_mch: NCH=2, MIN=1, MAX=3, SRC=3, FDEPTH=4,
// PSZ=8, ASZ=4, DSZ=8, RSZ=4 (20-bit message, 3 packets, 4 pad bits).
module tb_pakin_io_mch;
   localparam int NCH = 2, PSZ = 8, MSZ = 20, TMO = 300;

   logic src_clk = 1'b0;
   logic reset;
   always #5 src_clk = ~src_clk;

   pakin_io_mch_if #(.NCH(NCH), .PSZ(PSZ), .MSZ(MSZ)) bus ();
   logic [1:0] err_src, err_red, err_seq;
   logic [3:0] dbg_dat;
`ifdef PAKIN_IO_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   pakin_io_mch #(.NCH(2), .MIN_ADDR(1), .MAX_ADDR(3), .SRC_ADDR(3), .FDEPTH(4)) dut (
      .src_clk (src_clk),
      .reset   (reset),
      .bus     (bus.master),
      .err_src (err_src),
      .err_red (err_red),
      .err_seq (err_seq),
      .dbg_dat (dbg_dat)
`ifdef PAKIN_IO_ERR_CNT_EN
      ,.err_cnt (err_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expired(input string tag);
      total++;
      bad++;
      $display("FAIL %s observed=timeout expected=handshake", tag);
   endtask

   // nibble-wise XOR of {src,dst,dat}
   function automatic logic [3:0] red4(input logic [3:0] s, input logic [3:0] d, input logic [7:0] t);
      return s ^ d ^ t[7:4] ^ t[3:0];
   endfunction

   function automatic logic [19:0] mk(input logic [3:0] s, input logic [3:0] d, input logic [7:0] t);
      return {s, d, t, red4(s, d, t)};
   endfunction

   task automatic recv_pkt(input int ch, output logic [7:0] p);
      int n;
      n = 0;
      p = '0;
      while (bus.o_req[ch] !== 1'b1 && n < TMO) begin @(negedge src_clk); n++; end
      if (n >= TMO) begin expired("recv_req_hi"); return; end
      p = bus.o_pakio[ch*PSZ +: PSZ];
      bus.o_ack[ch] = 1'b1;
      n = 0;
      while (bus.o_req[ch] !== 1'b0 && n < TMO) begin @(negedge src_clk); n++; end
      if (n >= TMO) expired("recv_req_lo");
      bus.o_ack[ch] = 1'b0;
   endtask

   task automatic recv_msg(input int ch, output logic [19:0] m, output logic [3:0] pad);
      logic [7:0] p0, p1, p2;
      logic [23:0] all;
      recv_pkt(ch, p0);
      recv_pkt(ch, p1);
      recv_pkt(ch, p2);
      all = {p0, p1, p2};
      m   = all[23:4];
      pad = all[3:0];
   endtask

   task automatic send_msg(input int ch, input logic [19:0] m);
      int n;
      bus.i_msg[ch*MSZ +: MSZ] = m;
      bus.i_req[ch] = 1'b1;
      n = 0;
      while (bus.i_ack[ch] !== 1'b1 && n < TMO) begin @(negedge src_clk); n++; end
      if (n >= TMO) expired("send_ack_hi");
      bus.i_req[ch] = 1'b0;
      n = 0;
      while (bus.i_ack[ch] !== 1'b0 && n < TMO) begin @(negedge src_clk); n++; end
      if (n >= TMO) expired("send_ack_lo");
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] m;
      logic [3:0]  pad, d;
      logic [7:0]  t;
      logic [7:0]  pk0;
      int          n;

      reset       = 1'b0;
      bus.o_ack   = '0;
      bus.i_req   = '0;
      bus.i_msg   = '0;
      repeat (3) @(negedge src_clk);

      // reset state
      chk("rst_o_req",  32'(bus.o_req),  32'h0);
      chk("rst_i_ack",  32'(bus.i_ack),  32'h0);
      chk("rst_pakio",  32'(bus.o_pakio), 32'h0);
      chk("rst_errs",   32'({err_src, err_red, err_seq}), 32'h0);
      chk("rst_dbg",    32'(dbg_dat), 32'h0);
      reset = 1'b1;

      // T1: loopback ch0, dst 1,2,3,1 and dat 5..8
      for (int i = 0; i < 4; i++) begin
         d = 4'((i % 3) + 1);
         t = 8'(5 + i);
         recv_msg(0, m, pad);
         chk("t1_msg", 32'(m), 32'(mk(4'd3, d, t)));
         chk("t1_pad", 32'(pad), 32'h0);
         send_msg(0, m);
         chk("t1_dbg",  32'(dbg_dat), 32'(t[3:0]));
         chk("t1_errs", 32'({err_src[0], err_red[0], err_seq[0]}), 32'h0);
      end

      // T2: bad src on ch0 (dat 9 continues the sequence), then a clean message
      send_msg(0, mk(4'd2, 4'd1, 8'd9));
      chk("t2_src",  32'(err_src), 32'b01);
      chk("t2_red",  32'(err_red), 32'b00);
      chk("t2_seq",  32'(err_seq), 32'b00);
      send_msg(0, mk(4'd3, 4'd1, 8'd10));
      chk("t2_src_sticky", 32'(err_src), 32'b01);
      chk("t2_seq_clean",  32'(err_seq), 32'b00);

      // T4: sequence gap on ch1: 7, 9, 10
      send_msg(1, mk(4'd3, 4'd2, 8'd7));
      chk("t4_first", 32'(err_seq[1]), 32'h0);
      send_msg(1, mk(4'd3, 4'd2, 8'd9));
      chk("t4_gap",   32'(err_seq[1]), 32'h1);
`ifdef PAKIN_IO_ERR_CNT_EN
      chk("t4_cnt1",  32'(err_cnt[15:8]), 32'd1);
`endif
      send_msg(1, mk(4'd3, 4'd2, 8'd10));
`ifdef PAKIN_IO_ERR_CNT_EN
      chk("t4_cnt_hold", 32'(err_cnt[15:8]), 32'd1);
`endif
      chk("t4_other_flags", 32'({err_src[1], err_red[1]}), 32'h0);
      chk("t4_dbg_ch0_only", 32'(dbg_dat), 32'hA);

      // T6: reset while o_req[0]=1 and i_ack[1]=1, checked before any clock edge
      bus.i_msg[MSZ +: MSZ] = mk(4'd3, 4'd1, 8'h40);
      bus.i_req[1] = 1'b1;
      n = 0;
      while (bus.i_ack[1] !== 1'b1 && n < TMO) begin @(negedge src_clk); n++; end
      if (n >= TMO) expired("t6_ack_hi");
      n = 0;
      while (bus.o_req[0] !== 1'b1 && n < TMO) begin @(negedge src_clk); n++; end
      if (n >= TMO) expired("t6_req_hi");
      #1 reset = 1'b0;
      #1;
      chk("t6_o_req", 32'(bus.o_req), 32'h0);
      chk("t6_i_ack", 32'(bus.i_ack), 32'h0);
      chk("t6_errs",  32'({err_src, err_red, err_seq}), 32'h0);
      bus.i_req = '0;
      repeat (3) @(negedge src_clk);
      reset = 1'b1;

      // T5: hold o_ack low; first packet must stay presented and stable
      n = 0;
      while (bus.o_req[0] !== 1'b1 && n < TMO) begin @(negedge src_clk); n++; end
      if (n >= TMO) expired("t5_req_hi");
      pk0 = bus.o_pakio[7:0];
      chk("t5_first_pkt", 32'(pk0), 32'h31);
      repeat (80) @(negedge src_clk);
      chk("t5_req_held",   32'(bus.o_req[0]), 32'h1);
      chk("t5_pkt_stable", 32'(bus.o_pakio[7:0]), 32'h31);
      for (int i = 0; i < 7; i++) begin
         d = 4'((i % 3) + 1);
         t = 8'(5 + i);
         recv_msg(0, m, pad);
         chk("t5_msg", 32'(m), 32'(mk(4'd3, d, t)));
      end

      // T3: flipped red LSB on fresh ch1
      t = 8'h33;
      send_msg(1, mk(4'd3, 4'd2, t) ^ 20'h1);
      chk("t3_red",  32'(err_red), 32'b10);
      chk("t3_src",  32'(err_src), 32'b00);
      chk("t3_seq_fresh", 32'(err_seq), 32'b00);
`ifdef PAKIN_IO_ERR_CNT_EN
      chk("t3_cnt1", 32'(err_cnt[15:8]), 32'd1);
      for (int i = 1; i < 300; i++) begin
         t = t + 8'd1;
         send_msg(1, mk(4'd3, 4'd2, t) ^ 20'h1);
      end
      chk("t3_cnt_sat", 32'(err_cnt[15:8]), 32'd255);
      chk("t3_cnt_ch0", 32'(err_cnt[7:0]),  32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
